// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, Run/Ready/Busy handshake, divide-by-zero flag.
// Optional two's-complement support is enabled with `define SEQ_DIVIDER_SIGNED_EN.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             Signed_mode,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Ready,
    output logic             Busy,
    output logic             Div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             zero;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] dividend_in;
    logic [WIDTH-1:0] divisor_in;
    logic             neg_q_in;
    logic             neg_r_in;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

`ifdef SEQ_DIVIDER_SIGNED_EN
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? -v : v;
    endfunction

    always_comb begin
        dividend_in = magnitude(Dividend, Signed_mode);
        divisor_in  = magnitude(Divisor, Signed_mode);
        neg_q_in    = Signed_mode & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
        neg_r_in    = Signed_mode & Dividend[WIDTH-1];
        q_res       = neg_q ? -q : q;
        r_res       = neg_r ? -rem : rem;
    end
`else
    logic signed_mode_unused;

    always_comb begin
        dividend_in = Dividend;
        divisor_in  = Divisor;
        neg_q_in    = 1'b0;
        neg_r_in    = 1'b0;
        q_res       = q;
        r_res       = rem;
    end

    assign neg_q              = 1'b0;
    assign neg_r              = 1'b0;
    assign signed_mode_unused = Signed_mode;
`endif

    // The kept partial remainder is always below the divisor, so WIDTH bits hold it;
    // only the shifted trial value needs the extra bit.
    assign shifted = {rem, q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            Quotient  <= '0;
            Remainder <= '0;
            Ready     <= 1'b0;
            Busy      <= 1'b0;
            Div_zero  <= 1'b0;
            cnt       <= '0;
            rem       <= '0;
            q         <= '0;
            dvs       <= '0;
            zero      <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        Ready    <= 1'b0;
                        Div_zero <= 1'b0;
                        Busy     <= 1'b1;
                        dvs      <= divisor_in;
                        rem      <= '0;
                        cnt      <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q    <= neg_q_in;
                        neg_r    <= neg_r_in;
`endif
                        // Divide-by-zero keeps the raw dividend in q for the remainder output.
                        if (Divisor == '0) begin
                            zero  <= 1'b1;
                            q     <= Dividend;
                            state <= FIX;
                        end else begin
                            zero  <= 1'b0;
                            q     <= dividend_in;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], ~diff[WIDTH]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (zero) begin
                        Quotient  <= '1;
                        Remainder <= q;
                        Div_zero  <= 1'b1;
                    end else begin
                        Quotient  <= q_res;
                        Remainder <= r_res;
                    end
                    Ready <= 1'b1;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SEQ_DIVIDER_SIGNED_EN
    logic neg_in_unused;
    assign neg_in_unused = neg_q_in | neg_r_in;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: 32-bit and 8-bit instances, handshake, latency and corner cases.
module tb_seq_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Run = 1'b0;
    logic        Signed_mode = 1'b0;
    logic [31:0] Dividend = '0;
    logic [31:0] Divisor = '0;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        Ready;
    logic        Busy;
    logic        Div_zero;

    logic        run8 = 1'b0;
    logic [7:0]  dd8 = '0;
    logic [7:0]  dv8 = '0;
    logic [7:0]  q8;
    logic [7:0]  r8;
    logic        ready8;
    logic        busy8;
    logic        dz8;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32)) dut (
        .clk(clk), .Reset_n(Reset_n), .Run(Run), .Signed_mode(Signed_mode),
        .Dividend(Dividend), .Divisor(Divisor), .Quotient(Quotient),
        .Remainder(Remainder), .Ready(Ready), .Busy(Busy), .Div_zero(Div_zero)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .Reset_n(Reset_n), .Run(run8), .Signed_mode(1'b0),
        .Dividend(dd8), .Divisor(dv8), .Quotient(q8),
        .Remainder(r8), .Ready(ready8), .Busy(busy8), .Div_zero(dz8)
    );

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sm);
        exp_t   e;
        longint sa;
        longint sd;
        e.lat = 33;
        e.z   = 1'b0;
        sa    = 0;
        sd    = 0;
        if (b == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.z   = 1'b1;
            e.lat = 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
`ifdef SEQ_DIVIDER_SIGNED_EN
            if (sm) begin
                sa  = longint'(signed'(a));
                sd  = longint'(signed'(b));
                e.q = 32'(sa / sd);
                e.r = 32'(sa % sd);
            end
`endif
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic z, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.z = z; e.lat = lat;
        return e;
    endfunction

    // Accept edge: pushes the expected result and checks the accept-edge outputs.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sm,
                            input exp_t e, input logic hold);
        @(negedge clk);
        Run = 1'b1; Dividend = a; Divisor = b; Signed_mode = sm;
        @(posedge clk);
        sb.push_back(e);
        #1;
        vectors++;
        if (Busy !== 1'b1 || Ready !== 1'b0 || Div_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL accept: busy/ready/dz = %b%b%b, required 100", Busy, Ready, Div_zero);
        end
        @(negedge clk);
        if (!hold) Run = 1'b0;
    endtask

    // Waits for Ready, counting edges from the accept edge (n0 edges already consumed).
    task automatic wait_result(input string name, input int n0);
        int   n;
        logic got;
        exp_t e;
        n   = n0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (Ready === 1'b1) begin
                got = 1'b1;
            end else begin
                vectors++;
                if (Busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s busy at edge %0d: got %b, required 1", name, n, Busy);
                end
            end
        end
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s timeout: Ready never rose, required at edge %0d", name, e.lat);
            return;
        end
        if (n !== e.lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d, required %0d", name, n, e.lat);
        end
        vectors++;
        if (Quotient !== e.q || Remainder !== e.r) begin
            miscompares++;
            $display("FAIL %s result: got q=%h r=%h, required q=%h r=%h", name, Quotient, Remainder, e.q, e.r);
        end
        vectors++;
        if (Div_zero !== e.z || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s flags: got dz=%b busy=%b, required dz=%b busy=0", name, Div_zero, Busy, e.z);
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({Quotient, Remainder, Ready, Busy, Div_zero} !== '0 ||
            {q8, r8, ready8, busy8, dz8} !== '0) begin
            miscompares++;
            $display("FAIL reset: got q=%h r=%h rdy=%b busy=%b dz=%b, required all 0",
                     Quotient, Remainder, Ready, Busy, Div_zero);
        end
        @(negedge clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [31:0] a;
        logic [31:0] b;
        start_op(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0, 33), 1'b0);
        wait_result("u100_7", 0);
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom >> (i * 8);
            if (b == 0) b = 32'd3;
            start_op(a, b, 1'b0, model(a, b, 1'b0), 1'b0);
            wait_result("urand", 0);
        end
        start_op(32'd5, 32'd9, 1'b0, mk(32'd0, 32'd5, 1'b0, 33), 1'b0);
        wait_result("small_by_big", 0);
    endtask

    task automatic test_width8();
        int   n;
        exp_t e;
        @(negedge clk);
        run8 = 1'b1; dd8 = 8'd255; dv8 = 8'd16;
        @(posedge clk);
        sb.push_back(mk(32'd15, 32'd15, 1'b0, 9));
        @(negedge clk);
        run8 = 1'b0;
        n = 0;
        while (ready8 !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        vectors++;
        if (n !== e.lat || ready8 !== 1'b1) begin
            miscompares++;
            $display("FAIL w8 latency: got %0d, required %0d", n, e.lat);
        end
        vectors++;
        if ({24'd0, q8} !== e.q || {24'd0, r8} !== e.r || dz8 !== e.z) begin
            miscompares++;
            $display("FAIL w8 result: got q=%h r=%h, required q=%h r=%h", q8, r8, e.q[7:0], e.r[7:0]);
        end
    endtask

    task automatic test_div_zero();
        start_op(32'h1234, 32'd0, 1'b0, mk(32'hFFFF_FFFF, 32'h1234, 1'b1, 1), 1'b0);
        wait_result("div0", 0);
        start_op(32'd50, 32'd5, 1'b0, mk(32'd10, 32'd0, 1'b0, 33), 1'b0);
        wait_result("after_div0", 0);
    endtask

    task automatic test_signed();
`ifdef SEQ_DIVIDER_SIGNED_EN
        start_op(-32'sd7, 32'd2, 1'b1, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33), 1'b0);
        wait_result("s_m7_2", 0);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h8000_0000, 32'd0, 1'b0, 33), 1'b0);
        wait_result("s_min_m1", 0);
`else
        start_op(-32'sd7, 32'd2, 1'b1, mk(32'h7FFF_FFFC, 32'd1, 1'b0, 33), 1'b0);
        wait_result("s_m7_2", 0);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'd0, 32'h8000_0000, 1'b0, 33), 1'b0);
        wait_result("s_min_m1", 0);
`endif
        start_op(32'd7, -32'sd3, 1'b1, model(32'd7, -32'sd3, 1'b1), 1'b0);
        wait_result("s_7_m3", 0);
        start_op(-32'sd7, 32'd2, 1'b0, mk(32'h7FFF_FFFC, 32'd1, 1'b0, 33), 1'b0);
        wait_result("s_mode_off", 0);
    endtask

    task automatic test_run_ignored();
        start_op(32'd1000, 32'd3, 1'b0, mk(32'd333, 32'd1, 1'b0, 33), 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        Run = 1'b1; Dividend = 32'd77; Divisor = 32'd5; Signed_mode = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Run = 1'b0;
        wait_result("run_ignored", 10);
    endtask

    task automatic test_back_to_back();
        start_op(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0, 33), 1'b1);
        wait_result("b2b_first", 0);
        @(negedge clk);
        Dividend = 32'd90; Divisor = 32'd4; Signed_mode = 1'b0;
        @(posedge clk);
        sb.push_back(mk(32'd22, 32'd2, 1'b0, 33));
        #1;
        vectors++;
        if (Busy !== 1'b1 || Ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b accept: got busy=%b ready=%b, required 1 0", Busy, Ready);
        end
        @(negedge clk);
        Run = 1'b0;
        wait_result("b2b_second", 0);
    endtask

    task automatic test_reset_mid_op();
        start_op(32'h5555_5555, 32'd3, 1'b0, model(32'h5555_5555, 32'd3, 1'b0), 1'b0);
        repeat (15) @(posedge clk);
        #3;
        Reset_n = 1'b0;
        #1;
        void'(sb.pop_back());
        vectors++;
        if ({Quotient, Remainder, Ready, Busy, Div_zero} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got q=%h r=%h rdy=%b busy=%b dz=%b, required all 0",
                     Quotient, Remainder, Ready, Busy, Div_zero);
        end
        @(negedge clk);
        Reset_n = 1'b1;
        start_op(32'd12345, 32'd100, 1'b0, mk(32'd123, 32'd45, 1'b0, 33), 1'b0);
        wait_result("after_reset", 0);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_width8();
        test_div_zero();
        test_signed();
        test_run_ignored();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
